// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage: 32-entry register file plus a four-state issue FSM
// (IDLE -> READ -> EXEC -> WB) that feeds a combinational ALU one MIPS
// R-type instruction at a time and writes the result back to rd.
//
// Handshake: an instruction transfers on a rising edge where both
// instr_valid_i and instr_ready_o are high. instr_ready_o is high only in
// IDLE while out of reset; instr_valid_i is ignored in every other state,
// so the source must hold its offer until it sees ready.
module rtype_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ld_en_i,
    input  logic [4:0]        ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              instr_valid_i,
    input  logic [31:0]       instr_i,
    output logic              instr_ready_o,
    output logic [DATA_W-1:0] alu_rs_o,
    output logic [DATA_W-1:0] alu_rt_o,
    output logic [4:0]        alu_shamt_o,
    output logic [5:0]        alu_funct_o,
    input  logic [DATA_W-1:0] alu_rd_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              illegal_o,
    input  logic [4:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, r_q;
    logic [4:0]        shamt_q;
    logic [5:0]        funct_q;

    // Instruction register fields
    logic [5:0] ir_op, ir_funct;
    logic [4:0] ir_rs, ir_rt, ir_rd, ir_shamt;
    logic       ir_legal, accept;
    logic [DATA_W-1:0] rs_val, rt_val;

    assign ir_op    = ir_q[31:26];
    assign ir_rs    = ir_q[25:21];
    assign ir_rt    = ir_q[20:16];
    assign ir_rd    = ir_q[15:11];
    assign ir_shamt = ir_q[10:6];
    assign ir_funct = ir_q[5:0];

    // Only add, sub and srl with opcode 0 are executed
    assign ir_legal = (ir_op == 6'd0) &&
                      ((ir_funct == 6'b100000) || (ir_funct == 6'b100010) ||
                       (ir_funct == 6'b000010));
    assign accept   = (state_q == S_IDLE) && instr_valid_i;

    // Register 0 is never written, but force zero so the read is obvious
    assign rs_val     = (ir_rs == 5'd0) ? '0 : regs_q[ir_rs];
    assign rt_val     = (ir_rt == 5'd0) ? '0 : regs_q[ir_rt];
    assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

    assign dbg_state_o = state_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: strictly serial, illegal instructions return from READ
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid_i) state_d = S_READ;
            S_READ:  state_d = ir_legal ? S_EXEC : S_IDLE;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; writeback and illegal pulses are suppressed under reset
    always_comb begin
        instr_ready_o = rst_n_i && (state_q == S_IDLE);
        wb_valid_o    = rst_n_i && (state_q == S_WB);
        wb_addr_o     = wb_valid_o ? ir_rd : 5'd0;
        wb_data_o     = wb_valid_o ? r_q : '0;
        illegal_o     = rst_n_i && (state_q == S_READ) && !ir_legal;
        alu_rs_o      = a_q;
        alu_rt_o      = b_q;
        alu_shamt_o   = shamt_q;
        alu_funct_o   = funct_q;
    end

    // Register file: preload in IDLE, writeback in WB, cleared on reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if ((state_q == S_IDLE) && ld_en_i && (ld_addr_i != 5'd0)) begin
            regs_q[ld_addr_i] <= ld_data_i;
        end else if ((state_q == S_WB) && (ir_rd != 5'd0)) begin
            regs_q[ir_rd] <= r_q;
        end
    end

    // Datapath registers; A/B/shamt/funct double as the held ALU drive
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            shamt_q <= '0;
            funct_q <= '0;
        end else begin
            if (accept) ir_q <= instr_i;
            if ((state_q == S_READ) && ir_legal) begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                shamt_q <= ir_shamt;
                funct_q <= ir_funct;
            end
            if (state_q == S_EXEC) r_q <= alu_rd_i;
        end
    end

endmodule

// File: tb/tb_rtype_issue_stage.sv
// Bench for rtype_issue_stage: an inline ALU, a cycle-level reference model
// of the issue behaviour, a per-cycle compare process and directed vectors
// with literal expectations at the key cycles.
module tb_rtype_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_rs, alu_rt, alu_rd;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_funct;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtype_issue_stage #(.DATA_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .instr_valid_i(instr_valid), .instr_i(instr), .instr_ready_o(instr_ready),
        .alu_rs_o(alu_rs), .alu_rt_o(alu_rt), .alu_shamt_o(alu_shamt),
        .alu_funct_o(alu_funct), .alu_rd_i(alu_rd),
        .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .illegal_o(illegal), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
        .dbg_state_o(dbg_state)
    );

    // Combinational ALU attached to the stage
    assign alu_rd = (alu_funct == 6'h20) ? alu_rs + alu_rt :
                    (alu_funct == 6'h22) ? alu_rs - alu_rt :
                    (alu_funct == 6'h02) ? alu_rt >> alu_shamt : 32'd0;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_ir, m_a, m_b, m_res;
    logic [4:0]  m_shamt;
    logic [5:0]  m_funct;
    int          m_since_accept = 0;  // 0: idle, 1..3: cycles after accept
    bit          m_init = 0;

    function automatic bit is_legal(logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[5:0] inside {6'h20, 6'h22, 6'h02});
    endfunction

    function automatic logic [31:0] exec(logic [5:0] f, logic [31:0] a,
                                         logic [31:0] b, logic [4:0] sh);
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h02:   return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ir = 0; m_a = 0; m_b = 0; m_res = 0; m_shamt = 0; m_funct = 0;
            m_since_accept = 0;
            m_init = 1;
        end else begin
            case (m_since_accept)
                0: begin
                    if (ld_en && ld_addr != 5'd0) m_regs[ld_addr] = ld_data;
                    if (instr_valid) begin
                        m_ir = instr;
                        m_since_accept = 1;
                    end
                end
                1: begin
                    if (!is_legal(m_ir)) m_since_accept = 0;
                    else begin
                        m_a = m_regs[m_ir[25:21]];
                        m_b = m_regs[m_ir[20:16]];
                        m_shamt = m_ir[10:6];
                        m_funct = m_ir[5:0];
                        m_since_accept = 2;
                    end
                end
                2: begin
                    m_res = exec(m_funct, m_a, m_b, m_shamt);
                    m_since_accept = 3;
                end
                default: begin
                    if (m_ir[15:11] != 5'd0) m_regs[m_ir[15:11]] = m_res;
                    m_since_accept = 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (!rst_n) check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        if (m_init) begin
            logic e_wb;
            e_wb = rst_n && (m_since_accept == 3);
            check("m_ready", {31'd0, instr_ready},
                  {31'd0, rst_n && (m_since_accept == 0)});
            check("m_wb_valid", {31'd0, wb_valid}, {31'd0, e_wb});
            check("m_wb_addr", {27'd0, wb_addr}, e_wb ? {27'd0, m_ir[15:11]} : 32'd0);
            check("m_wb_data", wb_data, e_wb ? m_res : 32'd0);
            check("m_illegal", {31'd0, illegal},
                  {31'd0, rst_n && (m_since_accept == 1) && !is_legal(m_ir)});
            check("m_alu_rs", alu_rs, m_a);
            check("m_alu_rt", alu_rt, m_b);
            check("m_alu_shamt", {27'd0, alu_shamt}, {27'd0, m_shamt});
            check("m_alu_funct", {26'd0, alu_funct}, {26'd0, m_funct});
            check("m_dbg", dbg_data, m_regs[dbg_addr]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Leaves the bench in cycle c+1 (first cycle after the accept edge)
    task automatic issue(input logic [31:0] i);
        instr_valid = 1'b1; instr = i;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [4:0] a,
                            input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = 0; ld_data = 0;
        instr_valid = 1'b0; instr = 0; dbg_addr = 0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_alu_rs", alu_rs, 32'd0);
        check("rst_alu_funct", {26'd0, alu_funct}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            read_reg("rst_dbg", 5'(i), 32'd0);
        end

        // add r3 = r1 + r2
        load(5'd1, 32'd0); load(5'd2, 32'd1);
        issue(32'h00221820);
        step(); step(); #1;
        check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("add_wb_addr", {27'd0, wb_addr}, 32'd3);
        check("add_wb_data", wb_data, 32'd1);
        step();
        read_reg("add_r3", 5'd3, 32'd1);
        check("add_ready", {31'd0, instr_ready}, 32'd1);

        // sub r4 = r7 - r3
        load(5'd7, 32'd7); load(5'd3, 32'd3);
        issue(32'h00E32022);
        step(); #1;
        check("sub_alu_rs", alu_rs, 32'd7);
        check("sub_alu_rt", alu_rt, 32'd3);
        step(); #1;
        check("sub_wb_data", wb_data, 32'd4);
        step();
        read_reg("sub_r4", 5'd4, 32'd4);

        // srl r6 = r5 >> 2
        load(5'd5, 32'd8);
        issue(32'h00053082);
        step(); #1;
        check("srl_shamt", {27'd0, alu_shamt}, 32'd2);
        check("srl_funct", {26'd0, alu_funct}, 32'd2);
        step(); #1;
        check("srl_wb_data", wb_data, 32'd2);
        step();
        read_reg("srl_r6", 5'd6, 32'd2);

        // add r0 = r1 + r2: pulse still appears, r0 stays zero
        issue(32'h00220020);
        step(); step(); #1;
        check("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("r0_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("r0_wb_data", wb_data, 32'd1);
        step();
        read_reg("r0_dbg", 5'd0, 32'd0);

        // illegal opcode
        issue(32'h20220020);
        #1;
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_no_wb", {31'd0, wb_valid}, 32'd0);
        step(); #1;
        check("ill_ready", {31'd0, instr_ready}, 32'd1);
        check("ill_pulse_end", {31'd0, illegal}, 32'd0);

        // Load and issue together; inputs offered while busy are ignored
        ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'd5;
        issue(32'h00221820);
        ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'd99;
        instr_valid = 1'b1; instr = 32'h00E32022;
        step();
        ld_en = 1'b0; instr_valid = 1'b0;
        step(); #1;
        check("ldiss_wb_data", wb_data, 32'd6);
        step();
        read_reg("ldiss_r2", 5'd2, 32'd1);
        read_reg("ldiss_r3", 5'd3, 32'd6);

        // Wraparound add: r10 = 0xFFFFFFFF + 2
        load(5'd8, 32'hFFFF_FFFF); load(5'd9, 32'd2);
        issue(32'h01095020);
        step(); step(); #1;
        check("wrap_wb_data", wb_data, 32'd1);
        step();
        read_reg("wrap_r10", 5'd10, 32'd1);

        // Reset during EXEC aborts the instruction
        issue(32'h00221820);
        step();
        rst_n = 1'b0;
        step(); #1;
        check("abort_no_wb", {31'd0, wb_valid}, 32'd0);
        check("abort_ready", {31'd0, instr_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            read_reg("abort_dbg", 5'(i), 32'd0);
            step();
        end
        check("abort_final_no_wb", {31'd0, wb_valid}, 32'd0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
